// File: rtl/angle_reducer_pkg.sv
// Shared encodings for the angle range reducer: FSM states and output mapping modes.
package angle_reducer_pkg;

  localparam logic [1:0] RED_IDLE   = 2'd0;
  localparam logic [1:0] RED_DIVIDE = 2'd1;
  localparam logic [1:0] RED_MAP    = 2'd2;
  localparam logic [1:0] RED_DONE   = 2'd3;

  localparam logic RED_MODE_FOLD   = 1'b1;
  localparam logic RED_MODE_OFFSET = 1'b0;

endpackage

// File: rtl/angle_fold.sv
// Combinational quadrant split of a reduced angle r in [0, 4Q): quadrant, mapped angle, sign flags.
module angle_fold
  import angle_reducer_pkg::*;
#(
  parameter int RW = 10
) (
  input  logic [RW-1:0] r,
  input  logic [RW-1:0] q,
  input  logic          mode_fold,
  output logic [1:0]    quadrant,
  output logic [RW-1:0] data_out,
  output logic          sin_neg,
  output logic          cos_neg
);

  logic [RW-1:0] q2;
  logic [RW-1:0] q3;
  logic [RW-1:0] q4;
  logic [RW-1:0] base;
  logic [RW-1:0] folded;

  assign q2 = q << 1;
  assign q3 = q2 + q;
  assign q4 = q << 2;

  // Boundaries belong to the upper quadrant, so Q, 2Q and 3Q land in quadrants 1, 2 and 3.
  always_comb begin
    quadrant = 2'd0;
    base     = '0;
    if (r >= q3) begin
      quadrant = 2'd3;
      base     = q3;
    end else if (r >= q2) begin
      quadrant = 2'd2;
      base     = q2;
    end else if (r >= q) begin
      quadrant = 2'd1;
      base     = q;
    end
  end

  always_comb begin
    folded = r;
    case (quadrant)
      2'd0: folded = r;
      2'd1: folded = q2 - r;
      2'd2: folded = r - q2;
      2'd3: folded = q4 - r;
      default: folded = r;
    endcase
  end

  assign data_out = (mode_fold == RED_MODE_FOLD) ? folded : (r - base);
  assign sin_neg  = quadrant[1];
  assign cos_neg  = quadrant[0] ^ quadrant[1];

endmodule

// File: rtl/angle_reducer.sv
// Multi-cycle angle range reducer: restoring modulo by FULL_CIRCLE, one input bit per cycle,
// followed by a single-cycle quadrant fold and a held result under valid/ready.
module angle_reducer
  import angle_reducer_pkg::*;
#(
  parameter int   DATA_WIDTH  = 32,
  parameter int   FULL_CIRCLE = 360,
  parameter int   SIGNED_IN   = 0,
  parameter logic MODE        = RED_MODE_FOLD
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          mode_fold,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [1:0]                    quadrant,
  output logic [$clog2(FULL_CIRCLE):0]  data_out,
  output logic                          sin_neg,
  output logic                          cos_neg
);

  localparam int RW = $clog2(FULL_CIRCLE) + 1;
  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [RW-1:0] FC   = RW'(FULL_CIRCLE);
  localparam logic [RW-1:0] QTR  = RW'(FULL_CIRCLE / 4);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] mag;
  logic                  neg;
  logic                  mode_r;
  logic [RW-1:0]         rem;
  logic [CW-1:0]         cnt;

  logic signed [DATA_WIDTH-1:0] din_s;
  logic                         neg_in;
  logic [DATA_WIDTH-1:0]        mag_in;
  logic [RW:0]                  shifted;
  logic [RW:0]                  trial;
  logic [RW-1:0]                rem_next;
  logic [RW-1:0]                r_map;
  logic [1:0]                   fold_q;
  logic [RW-1:0]                fold_d;
  logic                         fold_s;
  logic                         fold_c;

  // Two's-complement negate of the most-negative value yields 2^(DATA_WIDTH-1) as an unsigned magnitude.
  assign din_s  = data_in;
  assign neg_in = (SIGNED_IN != 0) && (din_s < 0);
  assign mag_in = neg_in ? (~data_in + 1'b1) : data_in;

  // rem < FULL_CIRCLE before the shift, so one conditional subtract restores it.
  assign shifted  = {rem, mag[DATA_WIDTH-1]};
  assign trial    = shifted - {1'b0, FC};
  assign rem_next = (shifted >= {1'b0, FC}) ? trial[RW-1:0] : shifted[RW-1:0];

  assign r_map = (neg && (rem != '0)) ? (FC - rem) : rem;

  angle_fold #(.RW(RW)) u_fold (
    .r         (r_map),
    .q         (QTR),
    .mode_fold (mode_r),
    .quadrant  (fold_q),
    .data_out  (fold_d),
    .sin_neg   (fold_s),
    .cos_neg   (fold_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RED_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      quadrant  <= 2'd0;
      data_out  <= '0;
      sin_neg   <= 1'b0;
      cos_neg   <= 1'b0;
      mag       <= '0;
      neg       <= 1'b0;
      mode_r    <= MODE;
      rem       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        RED_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            mag      <= mag_in;
            neg      <= neg_in;
            mode_r   <= mode_fold;
            rem      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RED_DIVIDE;
          end
        end
        RED_DIVIDE: begin
          rem <= rem_next;
          mag <= {mag[DATA_WIDTH-2:0], 1'b0};
          if (cnt == LAST) state <= RED_MAP;
          else             cnt   <= cnt + 1'b1;
        end
        RED_MAP: begin
          quadrant  <= fold_q;
          data_out  <= fold_d;
          sin_neg   <= fold_s;
          cos_neg   <= fold_c;
          out_valid <= 1'b1;
          state     <= RED_DONE;
        end
        RED_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= RED_IDLE;
          end
        end
        default: state <= RED_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_reducer.sv
// Directed bench for angle_reducer: unsigned, signed and 16-bit/1024-unit instances with hand-computed results.
module tb_angle_reducer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b1;

  logic        iv   [3];
  logic [31:0] din  [3];
  logic        mf   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic [1:0]  qd   [3];
  logic [10:0] dout [3];
  logic        sn   [3];
  logic        cn   [3];

  logic [9:0]  d0;
  logic [9:0]  d1;
  logic [10:0] d2;

  assign dout[0] = {1'b0, d0};
  assign dout[1] = {1'b0, d1};
  assign dout[2] = d2;

  angle_reducer #(.DATA_WIDTH(32), .FULL_CIRCLE(360), .SIGNED_IN(0)) u_uns (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(ir[0]), .data_in(din[0]),
    .mode_fold(mf[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .quadrant(qd[0]),
    .data_out(d0), .sin_neg(sn[0]), .cos_neg(cn[0])
  );

  angle_reducer #(.DATA_WIDTH(32), .FULL_CIRCLE(360), .SIGNED_IN(1)) u_sgn (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(ir[1]), .data_in(din[1]),
    .mode_fold(mf[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .quadrant(qd[1]),
    .data_out(d1), .sin_neg(sn[1]), .cos_neg(cn[1])
  );

  angle_reducer #(.DATA_WIDTH(16), .FULL_CIRCLE(1024), .SIGNED_IN(0)) u_wide (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(ir[2]), .data_in(din[2][15:0]),
    .mode_fold(mf[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .quadrant(qd[2]),
    .data_out(d2), .sin_neg(sn[2]), .cos_neg(cn[2])
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start(input int i, input logic [31:0] d, input logic m);
    int n;
    n = 0;
    @(negedge clk);
    while (ir[i] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("in_ready_before_%0d", i), 32'(ir[i]), 32'd1);
    iv[i]  = 1'b1;
    din[i] = d;
    mf[i]  = m;
    @(posedge clk);
    #1;
    iv[i]  = 1'b0;
    din[i] = 32'h0;
    mf[i]  = ~m;
    chk($sformatf("in_ready_busy_%0d", i), 32'(ir[i]), 32'd0);
  endtask

  task automatic wait_out(input int i, input int exp_lat);
    int n;
    n = 0;
    while (ov[i] !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk($sformatf("latency_%0d", i), 32'(n), 32'(exp_lat));
  endtask

  task automatic check_res(input int i, input string tag, input int q, input int d,
                           input int s, input int c);
    chk({tag, "_quadrant"}, 32'(qd[i]), 32'(q));
    chk({tag, "_data_out"}, 32'(dout[i]), 32'(d));
    chk({tag, "_sin_neg"}, 32'(sn[i]), 32'(s));
    chk({tag, "_cos_neg"}, 32'(cn[i]), 32'(c));
  endtask

  task automatic drain(input int i);
    @(negedge clk);
    ordy[i] = 1'b1;
    @(posedge clk);
    #1;
    ordy[i] = 1'b0;
    chk($sformatf("out_valid_drop_%0d", i), 32'(ov[i]), 32'd0);
    chk($sformatf("in_ready_return_%0d", i), 32'(ir[i]), 32'd1);
  endtask

  task automatic run(input int i, input logic [31:0] d, input logic m, input string tag,
                     input int q, input int dd, input int s, input int c);
    start(i, d, m);
    wait_out(i, (i == 2) ? 17 : 33);
    check_res(i, tag, q, dd, s, c);
    drain(i);
  endtask

  initial begin
    int hi_seen;
    logic [1:0]  hold_q;
    logic [10:0] hold_d;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; din[k] = 32'h0; mf[k] = 1'b1; ordy[k] = 1'b0;
    end

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(ir[0]), 32'd0);
    chk("rst_out_valid", 32'(ov[0]), 32'd0);
    chk("rst_outputs", {qd[0], dout[0], sn[0], cn[0]}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", 32'(ir[0]), 32'd1);

    // Unsigned, FULL_CIRCLE=360, Q=90
    run(0, 32'd360, 1'b1, "u360", 0, 0, 0, 0);
    run(0, 32'd135, 1'b1, "u135", 1, 45, 0, 1);
    run(0, 32'd200, 1'b1, "u200", 2, 20, 1, 1);
    run(0, 32'hFFFF_FFFF, 1'b1, "umax_fold", 2, 75, 1, 1);
    run(0, 32'hFFFF_FFFF, 1'b0, "umax_off", 2, 75, 1, 1);
    run(0, 32'd135, 1'b0, "u135_off", 1, 45, 0, 1);
    run(0, 32'd0, 1'b1, "u0", 0, 0, 0, 0);
    run(0, 32'd90, 1'b1, "b90", 1, 90, 0, 1);
    run(0, 32'd180, 1'b1, "b180", 2, 0, 1, 1);
    run(0, 32'd270, 1'b1, "b270", 3, 90, 1, 0);

    // Signed: -30 -> 330; -2^31 mod 360 = 360 - 128 = 232
    run(1, -32'sd30, 1'b1, "s_m30_fold", 3, 30, 1, 0);
    run(1, -32'sd30, 1'b0, "s_m30_off", 3, 60, 1, 0);
    run(1, -32'sd720, 1'b1, "s_m720", 0, 0, 0, 0);
    run(1, 32'h8000_0000, 1'b1, "s_minneg", 2, 52, 1, 1);
    run(1, 32'd200, 1'b1, "s_200", 2, 20, 1, 1);

    // 16-bit, FULL_CIRCLE=1024: 0x0A00 = 2560 -> 512
    run(2, 32'h0000_0A00, 1'b1, "w_a00", 2, 0, 1, 1);

    // in_valid pulse during DIVIDE must not disturb the angle in flight
    start(0, 32'd200, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    iv[0] = 1'b1; din[0] = 32'd90; mf[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0; din[0] = 32'd0;
    wait_out(0, 29);
    check_res(0, "ignore_iv", 2, 20, 1, 1);

    // Backpressure: result held while out_ready stays low
    hold_q = qd[0];
    hold_d = dout[0];
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", {ov[0], ir[0], qd[0], dout[0]}, {1'b1, 1'b0, hold_q, hold_d});
    end
    drain(0);

    // Leave a nonzero result on the outputs, then reset in the middle of DIVIDE
    run(0, 32'd270, 1'b1, "pre_rst", 3, 90, 1, 0);
    start(0, 32'd200, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_in_ready", 32'(ir[0]), 32'd0);
    chk("mid_rst_outputs", {qd[0], dout[0], sn[0], cn[0]}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(ir[0]), 32'd1);
    hi_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ov[0] === 1'b1) hi_seen = 1;
    end
    chk("no_partial_result", 32'(hi_seen), 32'd0);
    run(0, 32'd135, 1'b1, "after_rst", 1, 45, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
